max_select: RTL and testbench
=============================

// Module: max_select
// PURPOSE
//  Output-classification stage downstream of the final fully-connected layer.
//  Takes the output-layer activations as one parallel vector and scans them sequentially, one per clock.
//  Returns the argmax index (the detected digit) and the winning value.
//  Raises a sticky interrupt that software clears; the AXI-lite slave reads the index (offset 8).
// PARAMETERS
//  NUM_INPUT   10  number of activations per vector; legal range 2..256
//  DATA_WIDTH  16  width of each activation, signed two's-complement fixed point
//  IDX_WIDTH   $clog2(NUM_INPUT) (derived, min 1)  width of the index output
// PORTS
//  clk           in   1                     system clock; all state updates on the rising edge
//  rst           in   1                     synchronous, active-high reset
//  i_data        in   NUM_INPUT*DATA_WIDTH  activation vector; element k = i_data[k*DATA_WIDTH +: DATA_WIDTH]
//  i_valid       in   1                     i_data valid this cycle
//  o_ready       out  1                     block idle; a vector is accepted on an edge with i_valid & o_ready
//  o_data        out  IDX_WIDTH             argmax index of the last completed vector
//  o_max_value   out  DATA_WIDTH            winning activation of the last completed vector
//  o_data_valid  out  1                     one-cycle pulse: o_data/o_max_value just updated
//  o_intr        out  1                     sticky completion interrupt
//  i_intr_clr    in   1                     clears o_intr
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - state=IDLE; o_data=0, o_max_value=0, o_data_valid=0, o_intr=0
//   - o_ready=1 from the first cycle after reset
//  Interface rules:
//   - o_ready = (state==IDLE), decoded directly from the state register
//   - i_valid while o_ready=0 is ignored, not queued
//   - the vector is copied into an internal buffer on acceptance, so i_data may change afterwards
//  FSM (two states):
//   - IDLE: on i_valid, capture the vector; cur_max=elem0, cur_idx=0, cnt=1 -> SCAN
//   - SCAN: each edge compare elem[cnt] against cur_max as signed
//     - strictly greater -> cur_max/cur_idx take elem[cnt]/cnt
//     - equal -> no update (ties resolve to the lowest index)
//     - cnt increments
//     - when cnt==NUM_INPUT-1, that edge also writes the final result to o_data/o_max_value,
//       sets o_data_valid=1 and o_intr=1 -> IDLE
//  Latency and throughput:
//   - acceptance edge E0; result and o_data_valid visible after edge E(NUM_INPUT-1)
//   - o_data_valid clears on the next edge
//   - o_ready is high again in the same cycle as o_data_valid; a new vector can be accepted at E(NUM_INPUT)
//   - throughput: one vector per NUM_INPUT cycles
//  Outputs and interrupt:
//   - o_data/o_max_value hold their value until the next completion
//   - o_intr stays high until an edge with i_intr_clr=1
//   - set and clear on the same edge -> set wins (o_intr=1)
//   - i_intr_clr has no effect on any other state
//  Arithmetic:
//   - comparisons are full DATA_WIDTH signed; no saturation or truncation
//   - cnt is IDX_WIDTH+1 bits wide to avoid wrap at NUM_INPUT = 2^IDX_WIDTH
//  Reset during SCAN:
//   - scan aborted; all outputs return to reset values on that edge
//   - no o_data_valid pulse and no o_intr for the aborted vector
// TESTING
//  - Reset: hold rst 3 cycles -> o_ready=1, o_data=0, o_max_value=0, o_intr=0, o_data_valid=0.
//  - Basic argmax:
//    - stimulus: vector {0x0010,0x0200,0xFF00,0x0150,0,0,0,0,0x0300,0x0001}, one-cycle i_valid
//    - required: o_data=8, o_max_value=0x0300
//    - required: o_data_valid pulses exactly 9 cycles after acceptance, o_intr=1
//  - Signed values and ties:
//    - all elements 0x8000 except elem3=elem6=0xFFFF -> o_data=3, o_max_value=0xFFFF (negatives ranked correctly)
//    - all elements equal -> o_data=0
//  - Busy handling:
//    - hold i_valid high with vector A, then switch to vector B during SCAN
//    - required: result of A only; B accepted at E10; second pulse at E19
//  - Interrupt:
//    - i_intr_clr pulse after completion -> o_intr=0
//    - i_intr_clr asserted on the completion edge -> o_intr=1
//  - Reset mid-scan: rst at E4 -> no o_data_valid pulse, o_intr=0, o_ready=1; next vector completes normally.

Source files
------------

// File: rtl/max_select.sv
// max_select: sequential argmax over one activation vector.
// Ports: clk, rst, i_data/i_valid/o_ready in, o_data/o_max_value/o_data_valid/o_intr out, i_intr_clr in.
module max_select #(
    parameter int NUM_INPUT  = 10,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data,
    input  logic                            i_valid,
    output logic                            o_ready,
    output logic [IDX_WIDTH-1:0]            o_data,
    output logic [DATA_WIDTH-1:0]           o_max_value,
    output logic                            o_data_valid,
    output logic                            o_intr,
    input  logic                            i_intr_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH:0] LAST = (IDX_WIDTH+1)'(NUM_INPUT - 1);

    state_t                         r_state;
    state_t                         w_next_state;
    logic [NUM_INPUT*DATA_WIDTH-1:0] r_buf;
    logic signed [DATA_WIDTH-1:0]   r_cur_max;
    logic [IDX_WIDTH-1:0]           r_cur_idx;
    logic [IDX_WIDTH:0]             r_cnt;

    logic signed [DATA_WIDTH-1:0]   w_vec [NUM_INPUT];
    logic signed [DATA_WIDTH-1:0]   w_elem;
    logic signed [DATA_WIDTH-1:0]   w_fin_max;
    logic [IDX_WIDTH-1:0]           w_fin_idx;
    logic                           w_gt;
    logic                           w_accept;
    logic                           w_done;

    for (genvar k = 0; k < NUM_INPUT; k++) begin : g_vec
        assign w_vec[k] = r_buf[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // cnt never exceeds NUM_INPUT-1 while scanning, so the low bits suffice
    assign w_elem    = w_vec[r_cnt[IDX_WIDTH-1:0]];
    assign w_gt      = (w_elem > r_cur_max);
    assign w_fin_max = w_gt ? w_elem : r_cur_max;
    assign w_fin_idx = w_gt ? r_cnt[IDX_WIDTH-1:0] : r_cur_idx;

    assign o_ready = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (r_cnt == LAST) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf        <= '0;
            r_cur_max    <= '0;
            r_cur_idx    <= '0;
            r_cnt        <= '0;
            o_data       <= '0;
            o_max_value  <= '0;
            o_data_valid <= 1'b0;
            o_intr       <= 1'b0;
        end else begin
            o_data_valid <= w_done;
            if (w_accept) begin
                r_buf     <= i_data;
                r_cur_max <= i_data[DATA_WIDTH-1:0];
                r_cur_idx <= '0;
                r_cnt     <= (IDX_WIDTH+1)'(1);
            end else if (r_state == SCAN) begin
                r_cur_max <= w_fin_max;
                r_cur_idx <= w_fin_idx;
                r_cnt     <= r_cnt + 1'b1;
            end
            if (w_done) begin
                o_data      <= w_fin_idx;
                o_max_value <= w_fin_max;
            end
            // completion outranks a simultaneous clear
            if (w_done) begin
                o_intr <= 1'b1;
            end else if (i_intr_clr) begin
                o_intr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_max_select.sv
// tb_max_select: randomized self-checking bench for max_select.
// Reference argmax is computed from the whole vector in the bench.
module tb_max_select;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] i_data;
    logic            i_valid;
    logic            o_ready;
    logic [IW-1:0]   o_data;
    logic [DW-1:0]   o_max_value;
    logic            o_data_valid;
    logic            o_intr;
    logic            i_intr_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    max_select #(
        .NUM_INPUT (N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_max_value (o_max_value),
        .o_data_valid(o_data_valid),
        .o_intr      (o_intr),
        .i_intr_clr  (i_intr_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // max over the whole vector, then lowest index holding it
    task automatic model(input logic [N*DW-1:0] v, output int idx,
                         output logic [DW-1:0] mx);
        int best;
        logic signed [DW-1:0] e;
        best = -(1 << 30);
        for (int k = 0; k < N; k++) begin
            e = v[k*DW +: DW];
            if (int'(e) > best) best = int'(e);
        end
        idx = -1;
        for (int k = N - 1; k >= 0; k--) begin
            e = v[k*DW +: DW];
            if (int'(e) == best) idx = k;
        end
        mx = best[DW-1:0];
    endtask

    task automatic run_vec(input string tag, input logic [N*DW-1:0] v,
                           input bit clr_on_done);
        int idx;
        int lat;
        logic [DW-1:0] mx;
        model(v, idx, mx);
        i_data  = v;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_data  = ~v;
        lat = 0;
        for (int k = 1; k <= 3 * N; k++) begin
            if (clr_on_done && k == N - 1) i_intr_clr = 1'b1;
            tick();
            i_intr_clr = 1'b0;
            if (k == 4) check({tag, "_busy"}, 32'(o_ready), 32'd0);
            if (o_data_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, N - 1);
        check({tag, "_idx"}, 32'(o_data), 32'(idx));
        check({tag, "_max"}, 32'(o_max_value), 32'(mx));
        check({tag, "_intr"}, 32'(o_intr), 32'd1);
        check({tag, "_rdy"}, 32'(o_ready), 32'd1);
        tick();
        check({tag, "_dvclr"}, 32'(o_data_valid), 32'd0);
    endtask

    logic [N*DW-1:0] va;
    logic [N*DW-1:0] vb;
    int              ia;
    int              ib;
    logic [DW-1:0]   ma;
    logic [DW-1:0]   mb;
    int              pulses;
    int              p1;
    int              p2;
    logic [IW-1:0]   held_idx;

    initial begin
        rst        = 1'b1;
        i_data     = '0;
        i_valid    = 1'b0;
        i_intr_clr = 1'b0;
        repeat (3) tick();
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_max", 32'(o_max_value), 32'd0);
        check("rst_intr", 32'(o_intr), 32'd0);
        check("rst_dv", 32'(o_data_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(o_ready), 32'd1);

        va = '0;
        va[0*DW +: DW] = 16'h0010;
        va[1*DW +: DW] = 16'h0200;
        va[2*DW +: DW] = 16'hFF00;
        va[3*DW +: DW] = 16'h0150;
        va[8*DW +: DW] = 16'h0300;
        va[9*DW +: DW] = 16'h0001;
        run_vec("basic", va, 1'b0);
        check("basic_idx8", 32'(o_data), 32'd8);
        check("basic_max300", 32'(o_max_value), 32'h0300);

        for (int k = 0; k < N; k++) va[k*DW +: DW] = 16'h8000;
        va[3*DW +: DW] = 16'hFFFF;
        va[6*DW +: DW] = 16'hFFFF;
        run_vec("signed", va, 1'b0);
        check("signed_idx3", 32'(o_data), 32'd3);
        check("signed_ffff", 32'(o_max_value), 32'hFFFF);

        ma = 16'($urandom);
        for (int k = 0; k < N; k++) va[k*DW +: DW] = ma;
        run_vec("equal", va, 1'b0);
        check("equal_idx0", 32'(o_data), 32'd0);

        held_idx   = o_data;
        i_intr_clr = 1'b1;
        tick();
        i_intr_clr = 1'b0;
        check("clr_intr", 32'(o_intr), 32'd0);
        check("clr_keep", 32'(o_data), 32'(held_idx));

        for (int k = 0; k < N; k++) va[k*DW +: DW] = 16'($urandom);
        run_vec("setwins", va, 1'b1);

        for (int k = 0; k < N; k++) begin
            va[k*DW +: DW] = 16'($urandom_range(0, 16'h3FFF));
            vb[k*DW +: DW] = 16'($urandom_range(0, 16'h3FFF));
        end
        va[2*DW +: DW] = 16'h7000;
        vb[7*DW +: DW] = 16'h7FFF;
        model(va, ia, ma);
        model(vb, ib, mb);
        i_data  = va;
        i_valid = 1'b1;
        tick();
        pulses = 0;
        p1 = -1;
        p2 = -1;
        for (int t = 1; t <= 40; t++) begin
            if (t == 3) i_data = vb;
            tick();
            if (o_data_valid) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = t;
                    check("busy_a_idx", 32'(o_data), 32'(ia));
                    check("busy_a_max", 32'(o_max_value), 32'(ma));
                end else begin
                    p2 = t;
                    check("busy_b_idx", 32'(o_data), 32'(ib));
                    check("busy_b_max", 32'(o_max_value), 32'(mb));
                    break;
                end
            end
        end
        i_valid = 1'b0;
        check("busy_p1", p1, N - 1);
        check("busy_p2", p2, 2 * N - 1);
        tick();

        for (int k = 0; k < N; k++) va[k*DW +: DW] = 16'($urandom);
        i_data  = va;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_dv", 32'(o_data_valid), 32'd0);
        check("mid_intr", 32'(o_intr), 32'd0);
        check("mid_ready", 32'(o_ready), 32'd1);
        check("mid_data", 32'(o_data), 32'd0);
        pulses = 0;
        for (int t = 0; t < 2 * N; t++) begin
            tick();
            if (o_data_valid) pulses++;
        end
        check("mid_nopulse", pulses, 0);
        check("mid_intr2", 32'(o_intr), 32'd0);
        run_vec("after_mid", va, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N; k++) begin
                if (r[0]) va[k*DW +: DW] = 16'($urandom_range(0, 3) - 2);
                else      va[k*DW +: DW] = 16'($urandom);
            end
            run_vec($sformatf("rnd%0d", r), va, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
